// File: rtl/fc_pkg.sv
// Shared types for the fully-connected layer datapath.
// Loader FSM states, default layer sizing and the activation vector type.
package fc_pkg;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HOLD
    } fc_ld_state_t;

    localparam int FC_IN    = 128;
    localparam int FC_WIDTH = 8;

    // Parallel activation vector as seen by the combinational layer.
    typedef logic [FC_WIDTH-1:0] fc_act_vec_t [0:FC_IN-1];

endpackage

// File: rtl/fc_act_loader.sv
// Serial-to-parallel activation loader feeding the FC layer.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data/s_last beat
// stream in; x[0:IN-1]/x_valid/x_ready vector out; err_len length error pulse.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter  int WIDTH = FC_WIDTH,
    parameter  int IN    = FC_IN,
    localparam int IDX_W = $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_len
);

    fc_ld_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] x_q [0:IN-1];
    logic [WIDTH-1:0] x_d [0:IN-1];
    logic             x_valid_q;
    logic             err_len_q, err_len_d;
    logic             idx_last;

    assign idx_last = (idx_q == IDX_W'(IN - 1));

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            x_q       <= '{default: '0};
            x_valid_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= (state_d == HOLD);
            err_len_q <= err_len_d;
        end
    end

    // Next-state, index and vector update
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        err_len_d = 1'b0;
        unique case (state_q)
            FILL: begin
                // s_ready is high whenever FILL is active outside reset
                if (s_valid) begin
                    x_d[idx_q] = s_data;
                    if (idx_last) begin
                        state_d   = HOLD;
                        idx_d     = '0;
                        err_len_d = !s_last;
                    end else if (s_last) begin
                        state_d   = PAD;
                        idx_d     = idx_q + IDX_W'(1);
                        err_len_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PAD: begin
                x_d[idx_q] = '0;
                if (idx_last) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (x_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs: s_ready depends only on state and rst
    always_comb begin
        s_ready = (state_q == FILL) && !rst;
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign err_len = err_len_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader.
// Linear sequence of steps with immediate assertions at each check.
module tb_fc_act_loader;

    localparam int W = 8;
    localparam int N = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic [W-1:0] x [0:N-1];
    logic         x_valid;
    logic         x_ready;
    logic         err_len;

    logic [W-1:0] exp_x [0:N-1];
    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int e0;
    int n;

    fc_act_loader #(.WIDTH(W), .IN(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_len === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_x(input string tag);
        for (int j = 0; j < N; j++) begin
            chk($sformatf("%s[%0d]", tag, j), int'(x[j]), int'(exp_x[j]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_hold();
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        chk("rel_x_valid", int'(x_valid), 0);
        chk("rel_s_ready", int'(s_ready), 1);
    endtask

    initial begin
        int vec;
        int last_rise;
        int f;
        int b;
        int cyc;
        bit acc;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        x_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_x_valid", int'(x_valid), 0);
        chk("rst_err_len", int'(err_len), 0);
        for (int j = 0; j < N; j++) exp_x[j] = '0;
        chk_x("rst_x");
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", int'(s_ready), 1);

        // Full frame 0..127, s_last on final beat
        e0 = err_cnt;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data = W'(i);
            s_last = (i == N - 1);
            step();
            if (i == N - 2) chk("f1_no_valid_early", int'(x_valid), 0);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("f1_x_valid", int'(x_valid), 1);
        chk("f1_s_ready", int'(s_ready), 0);
        for (int j = 0; j < N; j++) exp_x[j] = W'(j);
        chk_x("f1_x");
        chk("f1_err_cnt", err_cnt - e0, 0);

        // Hold with junk upstream traffic
        s_valid = 1'b1;
        s_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_x_valid", int'(x_valid), 1);
            chk("hold_s_ready", int'(s_ready), 0);
        end
        chk_x("hold_x");
        release_hold();
        s_valid = 1'b0;

        // Short frame of 5 beats
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = W'(8'h11 + i);
            s_last = (i == 4);
            step();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("short_err_pulse", int'(err_len), 1);
        chk("short_s_ready", int'(s_ready), 0);
        n = 0;
        while (x_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("short_pad_cycles", n, 123);
        chk("short_err_cnt", err_cnt - e0, 1);
        for (int j = 0; j < N; j++) exp_x[j] = (j < 5) ? W'(8'h11 + j) : '0;
        chk_x("short_x");
        release_hold();

        // Missing last: 128 beats with s_last low
        e0 = err_cnt;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data = W'(i * 3);
            s_last = 1'b0;
            step();
        end
        chk("nolast_x_valid", int'(x_valid), 1);
        chk("nolast_err_pulse", int'(err_len), 1);
        s_data = 8'hAB;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nolast_stall", int'(s_ready), 0);
            chk("nolast_x0", int'(x[0]), 0);
        end
        chk("nolast_err_cnt", err_cnt - e0, 1);
        release_hold();
        step();
        chk("nolast_beat129_x0", int'(x[0]), 8'hAB);

        // Reset in mid-frame after beat 60
        for (int i = 1; i < 60; i++) begin
            s_data = W'(8'h40 + i);
            step();
        end
        e0 = err_cnt;
        rst = 1'b1;
        s_valid = 1'b0;
        step();
        chk("mrst_x_valid", int'(x_valid), 0);
        chk("mrst_s_ready", int'(s_ready), 0);
        chk("mrst_err_len", int'(err_len), 0);
        for (int j = 0; j < N; j++) exp_x[j] = '0;
        chk_x("mrst_x");
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data = W'(255 - i);
            s_last = (i == N - 1);
            step();
            if (i == N - 2) chk("fresh_no_valid_early", int'(x_valid), 0);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("fresh_x_valid", int'(x_valid), 1);
        chk("fresh_err_cnt", err_cnt - e0, 0);
        for (int j = 0; j < N; j++) exp_x[j] = W'(255 - j);
        chk_x("fresh_x");
        release_hold();

        // Back-to-back frames, x_ready and s_valid tied high
        x_ready = 1'b1;
        vec = 0;
        last_rise = -1;
        f = 0;
        b = 0;
        cyc = 0;
        while (vec < 3 && cyc < 600) begin
            s_valid = (f < 3);
            s_data = W'(f * 37 + b);
            s_last = (b == N - 1);
            acc = s_valid && s_ready;
            step();
            cyc++;
            if (acc) begin
                b++;
                if (b == N) begin
                    b = 0;
                    f++;
                end
            end
            if (x_valid === 1'b1) begin
                for (int j = 0; j < N; j++) exp_x[j] = W'(vec * 37 + j);
                chk_x($sformatf("b2b%0d_x", vec));
                if (last_rise >= 0) chk("b2b_period", cyc - last_rise, 129);
                last_rise = cyc;
                vec++;
            end
        end
        chk("b2b_vectors", vec, 3);
        s_valid = 1'b0;
        x_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
